// File: rtl/proc_feeder_pkg.sv
// proc_feeder_pkg
// Shared definitions for the instruction feeder and anything that builds
// instruction words for it (loaders, benches).
//   - feederState_e : FSM state encoding of the feeder
//   - instruction field positions: opcode [15:13], imm flag [12], rX [11:9]
//   - opcode values: mv, mvt, add, sub
//   - encodeImm()   : packs an immediate-form instruction word
package proc_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } feederState_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int IMM_BIT = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Immediate-form word: opcode, imm flag set, destination register and a
  // 9-bit immediate in the low bits.
  function automatic logic [15:0] encodeImm(input logic [2:0] op,
                                            input logic [2:0] rx,
                                            input logic [8:0] imm);
    return {op, 1'b1, rx, imm};
  endfunction

endpackage

// File: rtl/proc_feeder_if.sv
// proc_feeder_if
// Bundles the loader/processor-facing signals of the feeder.
//   Start, Count, LdEn, LdAddr, LdData : program loader and run control
//   Done                               : processor completion, combinational
//   DIN, Run                           : instruction word and valid strobe
//   Busy, ProgDone, PC, Error          : status
// master modport: the feeder itself. slave modport: loader/processor side.
interface proc_feeder_if #(
  parameter int AW = 5
);
  logic          Start;
  logic [AW:0]   Count;
  logic          LdEn;
  logic [AW-1:0] LdAddr;
  logic [15:0]   LdData;
  logic          Done;
  logic [15:0]   DIN;
  logic          Run;
  logic          Busy;
  logic          ProgDone;
  logic [AW-1:0] PC;
  logic          Error;

  modport master (
    input  Start, Count, LdEn, LdAddr, LdData, Done,
    output DIN, Run, Busy, ProgDone, PC, Error
  );

  modport slave (
    output Start, Count, LdEn, LdAddr, LdData, Done,
    input  DIN, Run, Busy, ProgDone, PC, Error
  );
endinterface

// File: rtl/proc_feeder_prog_mem.sv
// prog_mem
// DEPTH x 16 program memory with one write port and a registered read port,
// written so that synthesis maps it onto block RAM (no reset on the array or
// the read register).
//   Clock    : rising-edge clock
//   wrEn_i   : write enable
//   wrAddr_i : write address
//   wrData_i : write data
//   rdEn_i   : read enable; rdData_o only changes on an enabled read
//   rdAddr_i : read address
//   rdData_o : read data, valid the cycle after rdEn_i
module prog_mem
  import proc_feeder_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          Clock,
  input  logic          wrEn_i,
  input  logic [AW-1:0] wrAddr_i,
  input  logic [15:0]   wrData_i,
  input  logic          rdEn_i,
  input  logic [AW-1:0] rdAddr_i,
  output logic [15:0]   rdData_o
);

  logic [15:0] mem_q [DEPTH];
  logic [15:0] rdData_q;

  // Single write port plus an enabled synchronous read. Holding the read
  // register between reads lets the feeder keep presenting the instruction
  // during WAIT without its own copy of the word.
  always_ff @(posedge Clock) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
    if (rdEn_i) begin
      rdData_q <= mem_q[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/proc_feeder.sv
// proc_feeder
// Instruction sequencer for the lab processor: runs Count words out of a
// small program memory, one at a time, strobing Run for one cycle per word
// and waiting for the processor's Done before fetching the next.
//   Clock : rising-edge clock
//   Reset : synchronous, active-high
//   bus   : proc_feeder_if master modport (loader, processor and status)
// Optional: define PROC_FEEDER_TIMEOUT_EN to add a WAIT watchdog that sets
// Error and ends the program after TIMEOUT cycles without Done.
module proc_feeder
  import proc_feeder_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  proc_feeder_if.master bus
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  feederState_e  state_q;
  logic [AW-1:0] pc_q;
  logic [AW:0]   n_q;
  logic          run_q;
  logic          busy_q;
  logic          progDone_q;
  logic          dinEn_q;
  logic [AW:0]   nLatch_d;
  logic          isLast;
  logic          loadWindow;
  logic [15:0]   rdData;

  // Instruction count to latch on Start, clamped to the memory size, and
  // the "this is the final instruction" test used when Done arrives.
  assign nLatch_d   = (bus.Count > DEPTH_W) ? DEPTH_W : bus.Count;
  assign isLast     = ({1'b0, pc_q} == (n_q - 1'b1));
  assign loadWindow = (state_q == ST_IDLE) || (state_q == ST_FINISH);

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uMem (
    .Clock    (Clock),
    .wrEn_i   (bus.LdEn && loadWindow),
    .wrAddr_i (bus.LdAddr),
    .wrData_i (bus.LdData),
    .rdEn_i   (state_q == ST_FETCH),
    .rdAddr_i (pc_q),
    .rdData_o (rdData)
  );

`ifdef PROC_FEEDER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wdogCnt_q;
  logic           error_q;
`endif

  // Main sequencer. Every status output is a register updated together with
  // the state it belongs to, so Busy/ProgDone/Run never glitch. Run defaults
  // low each cycle so it can only be a single-cycle strobe out of FETCH.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      n_q        <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      progDone_q <= 1'b0;
      dinEn_q    <= 1'b0;
`ifdef PROC_FEEDER_TIMEOUT_EN
      wdogCnt_q  <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      run_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FINISH: begin
          if (bus.Start) begin
            pc_q <= '0;
            n_q  <= nLatch_d;
`ifdef PROC_FEEDER_TIMEOUT_EN
            error_q <= 1'b0;
`endif
            if (nLatch_d == '0) begin
              state_q    <= ST_FINISH;
              busy_q     <= 1'b0;
              progDone_q <= 1'b1;
            end else begin
              state_q    <= ST_FETCH;
              busy_q     <= 1'b1;
              progDone_q <= 1'b0;
            end
          end
        end
        ST_FETCH: begin
          state_q <= ST_ISSUE;
          run_q   <= 1'b1;
          dinEn_q <= 1'b1;
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
`ifdef PROC_FEEDER_TIMEOUT_EN
          wdogCnt_q <= '0;
`endif
        end
        ST_WAIT: begin
          if (bus.Done) begin
            dinEn_q <= 1'b0;
            if (isLast) begin
              state_q    <= ST_FINISH;
              busy_q     <= 1'b0;
              progDone_q <= 1'b1;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= ST_FETCH;
            end
          end
`ifdef PROC_FEEDER_TIMEOUT_EN
          else if (wdogCnt_q == WD_LAST) begin
            error_q    <= 1'b1;
            dinEn_q    <= 1'b0;
            state_q    <= ST_FINISH;
            busy_q     <= 1'b0;
            progDone_q <= 1'b1;
          end else begin
            wdogCnt_q <= wdogCnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          progDone_q <= 1'b0;
          dinEn_q    <= 1'b0;
        end
      endcase
    end
  end

  // The memory read register already holds the instruction from ISSUE
  // through WAIT; dinEn_q just forces zero everywhere else.
  assign bus.DIN      = dinEn_q ? rdData : 16'h0000;
  assign bus.Run      = run_q;
  assign bus.Busy     = busy_q;
  assign bus.ProgDone = progDone_q;
  assign bus.PC       = pc_q;

`ifdef PROC_FEEDER_TIMEOUT_EN
  assign bus.Error = error_q;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT;
  assign bus.Error     = 1'b0;
`endif

endmodule

// File: tb/tb_proc_feeder.sv
// tb_proc_feeder
// Bench for proc_feeder with a small behavioural model of the lab processor
// (mv/mvt finish one cycle after T0, add/sub three cycles after T0, Done is
// combinational). A table of short programs exercises the main sequencing;
// hand-written sequences cover clamping, blocked loads, reset mid-program,
// load-with-start and the WAIT watchdog (PROC_FEEDER_TIMEOUT_EN).
module tb_proc_feeder;
  import proc_feeder_pkg::*;

  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 16;

  logic Clock;
  logic Reset;
  logic doneStuck;

  int checks;
  int errors;

  proc_feeder_if #(.AW(AW)) bus ();

  proc_feeder #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Processor model: samples Run in T0, counts down its execute cycles and
  // raises Done in the last one, writing the register on that edge. With
  // doneStuck set it hangs in its last cycle without ever raising Done.
  logic [1:0]  procCnt;
  logic [15:0] procInstr;
  logic [15:0] procRegs [8];

  always @(posedge Clock) begin
    if (Reset) begin
      procCnt <= 2'd0;
    end else if (procCnt == 2'd0) begin
      if (bus.Run) begin
        procInstr <= bus.DIN;
        procCnt   <= (bus.DIN[OPC_MSB:OPC_LSB] == OP_ADD ||
                      bus.DIN[OPC_MSB:OPC_LSB] == OP_SUB) ? 2'd3 : 2'd1;
      end
    end else if (procCnt == 2'd1) begin
      if (!doneStuck) begin
        procCnt <= 2'd0;
        case (procInstr[OPC_MSB:OPC_LSB])
          OP_MV:   procRegs[procInstr[RX_MSB:RX_LSB]] <= {7'd0, procInstr[8:0]};
          OP_MVT:  procRegs[procInstr[RX_MSB:RX_LSB]] <= {procInstr[7:0], 8'h00};
          OP_ADD:  procRegs[procInstr[RX_MSB:RX_LSB]] <=
                     procRegs[procInstr[RX_MSB:RX_LSB]] + {7'd0, procInstr[8:0]};
          OP_SUB:  procRegs[procInstr[RX_MSB:RX_LSB]] <=
                     procRegs[procInstr[RX_MSB:RX_LSB]] - {7'd0, procInstr[8:0]};
          default: ;
        endcase
      end
    end else begin
      procCnt <= procCnt - 2'd1;
    end
  end

  assign bus.Done = (procCnt == 2'd1) && !doneStuck;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: simulation still running at 2 ms, required finished");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of loader/control inputs, then returns them to idle.
  task automatic applyStimulus(input logic start, input logic [AW:0] count,
                               input logic ldEn, input logic [AW-1:0] ldAddr,
                               input logic [15:0] ldData);
    bus.Start  = start;
    bus.Count  = count;
    bus.LdEn   = ldEn;
    bus.LdAddr = ldAddr;
    bus.LdData = ldData;
    tick();
    bus.Start = 1'b0;
    bus.LdEn  = 1'b0;
  endtask

  // Starts a program and follows it while Busy, counting Run pulses and
  // busy cycles and capturing the first issued word and when it appeared.
  task automatic runProgram(input logic [AW:0] count, input logic ldEn,
                            input logic [15:0] ldData,
                            output int pulses, output int cycles,
                            output logic [15:0] firstDin, output int firstRunIdx);
    applyStimulus(1'b1, count, ldEn, '0, ldData);
    pulses      = 0;
    cycles      = 0;
    firstDin    = 16'h0;
    firstRunIdx = -1;
    while (bus.Busy && cycles < 500) begin
      if (bus.Run) begin
        if (pulses == 0) begin
          firstDin    = bus.DIN;
          firstRunIdx = cycles;
        end
        pulses++;
      end
      cycles++;
      tick();
    end
    checkOutput("busyBound", {31'd0, bus.Busy}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [AW:0] count;
    int          expPulses;
    int          expPc;
    int          expCycles;
    logic [15:0] expR0;
    logic [15:0] expFirstDin;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          pulses;
    int          cycles;
    int          firstRunIdx;
    int          waitCycles;
    logic [15:0] firstDin;

    checks     = 0;
    errors     = 0;
    doneStuck  = 1'b0;
    bus.Start  = 1'b0;
    bus.Count  = '0;
    bus.LdEn   = 1'b0;
    bus.LdAddr = '0;
    bus.LdData = '0;
    for (int r = 0; r < 8; r++) procRegs[r] = 16'h0;

    // Busy cycles per instruction are 2 + execute cycles (mv 1, add/sub 3).
    vecs[0] = '{16'h1005, 16'h5003, 6'd2, 2, 1, 8, 16'd8,    16'h1005};
    vecs[1] = '{16'h1005, 16'h5003, 6'd1, 1, 0, 3, 16'd5,    16'h1005};
    vecs[2] = '{16'h1009, 16'h7004, 6'd2, 2, 1, 8, 16'd5,    16'h1009};
    vecs[3] = '{16'h100C, 16'h5003, 6'd0, 0, 0, 0, 16'd5,    16'h0000};
    vecs[4] = '{encodeImm(OP_MVT, 3'd0, 9'h012), encodeImm(OP_ADD, 3'd0, 9'd3),
                6'd2, 2, 1, 8, 16'h1203, encodeImm(OP_MVT, 3'd0, 9'h012)};

    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    checkOutput("rstRun",      {31'd0, bus.Run},      32'd0);
    checkOutput("rstDin",      {16'd0, bus.DIN},      32'd0);
    checkOutput("rstBusy",     {31'd0, bus.Busy},     32'd0);
    checkOutput("rstProgDone", {31'd0, bus.ProgDone}, 32'd0);
    checkOutput("rstPc",       {27'd0, bus.PC},       32'd0);
    checkOutput("rstError",    {31'd0, bus.Error},    32'd0);

    $display("[TB] table vectors");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1'b0, '0, 1'b1, 5'd0, vecs[v].w0);
      applyStimulus(1'b0, '0, 1'b1, 5'd1, vecs[v].w1);
      runProgram(vecs[v].count, 1'b0, 16'h0, pulses, cycles, firstDin, firstRunIdx);
      checkOutput($sformatf("v%0d pulses", v),   pulses,               vecs[v].expPulses);
      checkOutput($sformatf("v%0d cycles", v),   cycles,               vecs[v].expCycles);
      checkOutput($sformatf("v%0d pc", v),       {27'd0, bus.PC},      vecs[v].expPc);
      checkOutput($sformatf("v%0d progDone", v), {31'd0, bus.ProgDone}, 32'd1);
      checkOutput($sformatf("v%0d r0", v),       {16'd0, procRegs[0]}, {16'd0, vecs[v].expR0});
      checkOutput($sformatf("v%0d firstDin", v), {16'd0, firstDin},    {16'd0, vecs[v].expFirstDin});
      if (vecs[v].count != 0)
        checkOutput($sformatf("v%0d firstRunIdx", v), firstRunIdx, 1);
      checkOutput($sformatf("v%0d dinIdle", v),  {16'd0, bus.DIN},     32'd0);
    end

    $display("[TB] count clamp");
    for (int a = 0; a < DEPTH; a++)
      applyStimulus(1'b0, '0, 1'b1, AW'(a), encodeImm(OP_MV, 3'd0, 9'(a)));
    runProgram(6'd40, 1'b0, 16'h0, pulses, cycles, firstDin, firstRunIdx);
    checkOutput("clampPulses", pulses,               32);
    checkOutput("clampCycles", cycles,               96);
    checkOutput("clampPc",     {27'd0, bus.PC},      31);
    checkOutput("clampR0",     {16'd0, procRegs[0]}, 31);

    $display("[TB] load blocked during WAIT");
    applyStimulus(1'b0, '0, 1'b1, 5'd0, 16'h1005);
    applyStimulus(1'b1, 6'd1, 1'b0, '0, 16'h0);
    tick();
    tick();
    checkOutput("blkInWait", {31'd0, (bus.Busy && !bus.Run && bus.DIN == 16'h1005)}, 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 5'd0, 16'hFFFF);
    for (int i = 0; i < 10 && bus.Busy; i++) tick();
    runProgram(6'd1, 1'b0, 16'h0, pulses, cycles, firstDin, firstRunIdx);
    checkOutput("blkRerunDin", {16'd0, firstDin}, 32'h1005);
    checkOutput("blkRerunR0",  {16'd0, procRegs[0]}, 32'd5);

    $display("[TB] load together with start");
    runProgram(6'd1, 1'b1, 16'h100C, pulses, cycles, firstDin, firstRunIdx);
    checkOutput("ldStartDin", {16'd0, firstDin},    32'h100C);
    checkOutput("ldStartR0",  {16'd0, procRegs[0]}, 32'd12);

    $display("[TB] reset in WAIT of second instruction");
    applyStimulus(1'b0, '0, 1'b1, 5'd0, 16'h1005);
    applyStimulus(1'b0, '0, 1'b1, 5'd1, 16'h5003);
    applyStimulus(1'b1, 6'd2, 1'b0, '0, 16'h0);
    pulses = 0;
    for (int i = 0; i < 20 && !(pulses == 2 && !bus.Run); i++) begin
      if (bus.Run) pulses++;
      tick();
    end
    checkOutput("rmwReached", {31'd0, (pulses == 2 && bus.Busy && !bus.Run)}, 32'd1);
    Reset = 1'b1;
    tick();
    checkOutput("rmwRun",      {31'd0, bus.Run},      32'd0);
    checkOutput("rmwDin",      {16'd0, bus.DIN},      32'd0);
    checkOutput("rmwBusy",     {31'd0, bus.Busy},     32'd0);
    checkOutput("rmwProgDone", {31'd0, bus.ProgDone}, 32'd0);
    checkOutput("rmwPc",       {27'd0, bus.PC},       32'd0);
    Reset = 1'b0;
    runProgram(6'd2, 1'b0, 16'h0, pulses, cycles, firstDin, firstRunIdx);
    checkOutput("rmwRerunDin",    {16'd0, firstDin}, 32'h1005);
    checkOutput("rmwRerunPulses", pulses,            2);
    checkOutput("rmwRerunPc",     {27'd0, bus.PC},   1);
    checkOutput("rmwRerunR0",     {16'd0, procRegs[0]}, 32'd8);

    $display("[TB] Done stuck low in WAIT");
    doneStuck = 1'b1;
    applyStimulus(1'b1, 6'd1, 1'b0, '0, 16'h0);
    tick();
    tick();
    waitCycles = 0;
    while (bus.Busy && waitCycles < 40) begin
      waitCycles++;
      tick();
    end
`ifdef PROC_FEEDER_TIMEOUT_EN
    checkOutput("toWaitCycles", waitCycles,             TIMEOUT);
    checkOutput("toError",      {31'd0, bus.Error},     32'd1);
    checkOutput("toProgDone",   {31'd0, bus.ProgDone},  32'd1);
    checkOutput("toDin",        {16'd0, bus.DIN},       32'd0);
    tick();
    checkOutput("toErrorHeld",  {31'd0, bus.Error},     32'd1);
`else
    checkOutput("noToWaitCycles", waitCycles,            40);
    checkOutput("noToBusy",       {31'd0, bus.Busy},     32'd1);
    checkOutput("noToError",      {31'd0, bus.Error},    32'd0);
    checkOutput("noToProgDone",   {31'd0, bus.ProgDone}, 32'd0);
`endif
    doneStuck = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkOutput("toRstError", {31'd0, bus.Error}, 32'd0);
    checkOutput("toRstBusy",  {31'd0, bus.Busy},  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
